// File: rtl/global_defs.sv
// Global matrix geometry and boolean constants shared by the MPU blocks.
// M x N matrix, index fields [MBITS:0] / [NBITS:0].
package global_defs;

  localparam int M     = 3;
  localparam int N     = 3;
  localparam int MBITS = 1;
  localparam int NBITS = 1;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

endpackage

// File: rtl/mpu_data_types.sv
// MPU data types: single-precision element word and arbiter FSM states.
// Also derives the collector burst length and its counter width.
package mpu_data_types;

  import global_defs::*;

  typedef logic [31:0] float_sp;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOADER,
    ARB_COLLECTOR
  } arbiter_state_e;

  localparam int MN    = M * N;
  localparam int CNT_W = $clog2(MN + 1);

endpackage

// File: rtl/mpu_write_arbiter.sv
// Arbitrates the loader and collector onto the single matrix register-file write port.
// Collector has absolute priority; loader is valid/ready and may be stalled.
// Ports: clk, rst (sync, active-high); loader_* request with loader_ready_out;
// collector_* strobe and finished flag; reg_* registered write port;
// collector_done_out, collector_error_out (sticky), loader_timeout_out, busy_out.
module mpu_write_arbiter
  import global_defs::*;
  import mpu_data_types::*;
#(
  parameter int LOADER_MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loader_valid_in,
  output logic             loader_ready_out,
  input  logic [MBITS:0]   loader_i_in,
  input  logic [NBITS:0]   loader_j_in,
  input  float_sp          loader_element_in,
  input  logic             collector_active_write_in,
  input  logic [MBITS:0]   collector_i_in,
  input  logic [NBITS:0]   collector_j_in,
  input  float_sp          collector_element_in,
  input  logic             collector_finished_in,
  output logic             reg_wr_en_out,
  output logic [MBITS:0]   reg_i_out,
  output logic [NBITS:0]   reg_j_out,
  output float_sp          reg_element_out,
  output logic             collector_done_out,
  output logic             collector_error_out,
  output logic             loader_timeout_out,
  output logic             busy_out
);

  localparam int WAIT_W = $clog2(LOADER_MAX_WAIT + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(MN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(LOADER_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  arbiter_state_e state;
  arbiter_state_e state_nxt;

  logic [CNT_W-1:0]  coll_cnt;
  logic              fin_seen;
  logic              coll_ovf;
  logic [WAIT_W-1:0] wait_cnt;

  logic ready;
  logic loader_accept;
  logic loader_stall;
  logic coll_entry;
  logic coll_strobe_in_burst;
  logic coll_exit;

  always_comb begin
    ready = !rst
         && !collector_active_write_in
         && (state != ARB_COLLECTOR);
    loader_accept = loader_valid_in && ready;
    loader_stall  = loader_valid_in && !ready;
    coll_entry = collector_active_write_in
              && (state != ARB_COLLECTOR);
    coll_strobe_in_burst = collector_active_write_in
                        && (state == ARB_COLLECTOR);
    coll_exit = (state == ARB_COLLECTOR)
             && !collector_active_write_in;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (collector_active_write_in)
          state_nxt = ARB_COLLECTOR;
        else if (loader_valid_in)
          state_nxt = ARB_LOADER;
      end
      ARB_LOADER: begin
        if (collector_active_write_in)
          state_nxt = ARB_COLLECTOR;
        else if (!loader_valid_in)
          state_nxt = ARB_IDLE;
      end
      ARB_COLLECTOR: begin
        if (!collector_active_write_in)
          state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ARB_IDLE;
    else
      state <= state_nxt;
  end

  // Write port: one cycle behind the grant, zeroed when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_en_out   <= FALSE;
      reg_i_out       <= '0;
      reg_j_out       <= '0;
      reg_element_out <= '0;
    end else if (collector_active_write_in) begin
      reg_wr_en_out   <= TRUE;
      reg_i_out       <= collector_i_in;
      reg_j_out       <= collector_j_in;
      reg_element_out <= collector_element_in;
    end else if (loader_accept) begin
      reg_wr_en_out   <= TRUE;
      reg_i_out       <= loader_i_in;
      reg_j_out       <= loader_j_in;
      reg_element_out <= loader_element_in;
    end else begin
      reg_wr_en_out   <= FALSE;
      reg_i_out       <= '0;
      reg_j_out       <= '0;
      reg_element_out <= '0;
    end
  end

  // The entry strobe is itself the first element, so the count starts at 1.
  // An overflowing strobe flags the error at once and blocks the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt            <= '0;
      fin_seen            <= FALSE;
      coll_ovf            <= FALSE;
      collector_done_out  <= FALSE;
      collector_error_out <= FALSE;
    end else begin
      collector_done_out <= FALSE;
      if (coll_entry) begin
        coll_cnt <= CNT_ONE;
        fin_seen <= collector_finished_in;
        coll_ovf <= FALSE;
      end else if (coll_strobe_in_burst) begin
        if (collector_finished_in)
          fin_seen <= TRUE;
        if (coll_cnt == CNT_FULL) begin
          coll_ovf            <= TRUE;
          collector_error_out <= TRUE;
        end else begin
          coll_cnt <= coll_cnt + CNT_ONE;
        end
      end else if (coll_exit) begin
        if (coll_cnt != CNT_FULL)
          collector_error_out <= TRUE;
        else if ((fin_seen || collector_finished_in) && !coll_ovf)
          collector_done_out <= TRUE;
      end
    end
  end

  // Counter saturates at the limit so the timeout fires once per stall.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (loader_stall) begin
      if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WAIT_ONE;
    end else
      wait_cnt <= '0;
  end

  assign loader_ready_out   = ready;
  assign loader_timeout_out = !rst && loader_stall
                           && (wait_cnt == WAIT_MAX - WAIT_ONE);
  assign busy_out = !rst && (state != ARB_IDLE);

endmodule

// File: tb/tb_mpu_write_arbiter.sv
// Scoreboard bench for mpu_write_arbiter.
// Expected writes queued at grant time, compared one cycle later.
module tb_mpu_write_arbiter;

  import global_defs::*;
  import mpu_data_types::*;

  typedef logic [MBITS:0] mi_t;
  typedef logic [NBITS:0] nj_t;

  typedef struct packed {
    mi_t     i;
    nj_t     j;
    float_sp e;
  } wr_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    loader_valid_in;
  logic    loader_ready_out;
  mi_t     loader_i_in;
  nj_t     loader_j_in;
  float_sp loader_element_in;
  logic    collector_active_write_in;
  mi_t     collector_i_in;
  nj_t     collector_j_in;
  float_sp collector_element_in;
  logic    collector_finished_in;
  logic    reg_wr_en_out;
  mi_t     reg_i_out;
  nj_t     reg_j_out;
  float_sp reg_element_out;
  logic    collector_done_out;
  logic    collector_error_out;
  logic    loader_timeout_out;
  logic    busy_out;

  always #5 clk = ~clk;

  mpu_write_arbiter #(.LOADER_MAX_WAIT(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .loader_valid_in           (loader_valid_in),
    .loader_ready_out          (loader_ready_out),
    .loader_i_in               (loader_i_in),
    .loader_j_in               (loader_j_in),
    .loader_element_in         (loader_element_in),
    .collector_active_write_in (collector_active_write_in),
    .collector_i_in            (collector_i_in),
    .collector_j_in            (collector_j_in),
    .collector_element_in      (collector_element_in),
    .collector_finished_in     (collector_finished_in),
    .reg_wr_en_out             (reg_wr_en_out),
    .reg_i_out                 (reg_i_out),
    .reg_j_out                 (reg_j_out),
    .reg_element_out           (reg_element_out),
    .collector_done_out        (collector_done_out),
    .collector_error_out       (collector_error_out),
    .loader_timeout_out        (loader_timeout_out),
    .busy_out                  (busy_out)
  );

  int n_vec = 0;
  int n_err = 0;
  wr_t exp_q[$];
  arbiter_state_e ms = ARB_IDLE;
  int cyc_no = 0;
  int ld_k = 0;
  int stall = 0;
  int to_cnt = 0;
  int to_stall = 0;
  int done_cnt = 0;
  int resume = -1;
  int watch_from = 0;
  int base = 0;
  int ld0 = 0;
  int done0 = 0;
  logic last_ready;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic float_sp fp(input int k);
    int e;
    logic [31:0] m;
    logic [7:0] ex;
    if (k == 0) return 32'h0;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    m  = 32'(k) << (23 - e);
    ex = 8'(127 + e);
    return {1'b0, ex, m[22:0]};
  endfunction

  task automatic cyc(input logic c, input logic lv,
                     input int k, input logic fin);
    wr_t w;
    logic rdy_m;
    logic acc;
    collector_active_write_in = c;
    collector_i_in        = c ? mi_t'((k / N) % M) : '0;
    collector_j_in        = c ? nj_t'(k % N) : '0;
    collector_element_in  = c ? fp(k) : '0;
    collector_finished_in = fin;
    loader_valid_in   = lv;
    loader_i_in       = mi_t'(ld_k % M);
    loader_j_in       = nj_t'((ld_k / M) % N);
    loader_element_in = 32'hC000_0000 | 32'(ld_k);
    @(negedge clk);
    rdy_m = !rst && !c && (ms != ARB_COLLECTOR);
    last_ready = loader_ready_out;
    check("ready", {63'd0, loader_ready_out}, {63'd0, rdy_m});
    check("busy", {63'd0, busy_out},
          {63'd0, !rst && (ms != ARB_IDLE)});
    check("wr_en", {63'd0, reg_wr_en_out},
          {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      if (reg_wr_en_out)
        check("wr_data", 64'({reg_i_out, reg_j_out, reg_element_out}),
              64'(w));
    end else if (!reg_wr_en_out) begin
      check("wr_zero", 64'({reg_i_out, reg_j_out, reg_element_out}),
            64'd0);
    end
    acc = lv && rdy_m;
    if (!rst) begin
      if (c)
        exp_q.push_back({collector_i_in, collector_j_in,
                         collector_element_in});
      else if (acc)
        exp_q.push_back({loader_i_in, loader_j_in,
                         loader_element_in});
    end
    stall = (lv && !rdy_m) ? stall + 1 : 0;
    if (loader_timeout_out) begin
      to_cnt++;
      to_stall = stall;
    end
    if (collector_done_out) done_cnt++;
    if (acc && resume < 0 && cyc_no >= watch_from)
      resume = cyc_no - base;
    @(posedge clk);
    if (rst) ms = ARB_IDLE;
    else begin
      case (ms)
        ARB_IDLE:   ms = c ? ARB_COLLECTOR
                          : (lv ? ARB_LOADER : ARB_IDLE);
        ARB_LOADER: ms = c ? ARB_COLLECTOR
                          : (lv ? ARB_LOADER : ARB_IDLE);
        default:    ms = c ? ARB_COLLECTOR : ARB_IDLE;
      endcase
    end
    #1;
    if (acc) ld_k++;
    cyc_no++;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) cyc(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    loader_valid_in = 1'b0;
    collector_active_write_in = 1'b0;
    collector_finished_in = 1'b0;
    idle(2);
    rst = 1'b0;
    check("rst_outs",
          64'({reg_wr_en_out, reg_i_out, reg_j_out, reg_element_out,
               collector_done_out, collector_error_out,
               loader_timeout_out, busy_out}), 64'd0);

    // collector burst alone
    for (int k = 0; k < 9; k++) cyc(1'b1, 1'b0, k, k == 8);
    idle(3);
    check("burst_done", 64'(done_cnt), 64'd1);
    check("burst_err", {63'd0, collector_error_out}, 64'd0);

    // loader preempted by strobes at cycles 5..13
    base = cyc_no;
    ld0 = ld_k;
    resume = -1;
    watch_from = base + 14;
    for (int t = 0; t < 24; t++) begin
      cyc((t >= 5 && t <= 13), 1'b1, t - 5, t == 13);
      if (t >= 5 && t <= 13)
        check("pre_stall", {63'd0, last_ready}, 64'd0);
    end
    idle(2);
    check("pre_resume", 64'(resume), 64'd15);
    check("pre_ld_cnt", 64'(ld_k - ld0), 64'd14);
    check("pre_done", 64'(done_cnt), 64'd2);
    check("pre_err", {63'd0, collector_error_out}, 64'd0);

    // short burst of 7
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, k, k == 6);
    idle(3);
    check("short_err", {63'd0, collector_error_out}, 64'd1);
    idle(5);
    check("short_sticky", {63'd0, collector_error_out}, 64'd1);
    check("short_done", 64'(done_cnt), 64'd2);
    reset_pulse();
    check("short_clr", {63'd0, collector_error_out}, 64'd0);

    // timeout across a 16-strobe burst
    to_cnt = 0;
    cyc(1'b0, 1'b1, 0, 1'b0);
    cyc(1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, k, k == 15);
    for (int t = 0; t < 3; t++) cyc(1'b0, 1'b1, 0, 1'b0);
    idle(2);
    check("to_count", 64'(to_cnt), 64'd1);
    check("to_cycle", 64'(to_stall), 64'd16);
    check("to_ovf_err", {63'd0, collector_error_out}, 64'd1);
    reset_pulse();

    // reset in the middle of a burst
    done0 = done_cnt;
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, k, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 3, 1'b0);
    rst = 1'b0;
    check("mid_rst_outs",
          64'({reg_wr_en_out, reg_i_out, reg_j_out, reg_element_out,
               collector_done_out, collector_error_out,
               loader_timeout_out, busy_out}), 64'd0);
    idle(1);
    for (int k = 0; k < 9; k++) cyc(1'b1, 1'b0, k, k == 8);
    idle(3);
    check("mid_rst_done", 64'(done_cnt - done0), 64'd1);
    check("mid_rst_err", {63'd0, collector_error_out}, 64'd0);

    // loader and collector rise together
    done0 = done_cnt;
    base = cyc_no;
    resume = -1;
    watch_from = base;
    for (int t = 0; t < 13; t++) cyc(t < 9, 1'b1, t, t == 8);
    idle(3);
    check("sim_resume", 64'(resume), 64'd10);
    check("sim_done", 64'(done_cnt - done0), 64'd1);
    check("sim_err", {63'd0, collector_error_out}, 64'd0);
    check("q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpu_write_arbiter.md
MPU_WRITE_ARBITER -- requirements
Module: mpu_write_arbiter

Interface
REQ-001 SHALL have parameter LOADER_MAX_WAIT, default 16: number of consecutive stalled cycles of a valid loader request before loader_timeout_out pulses.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port loader_valid_in, input, 1: loader presents one element write.
REQ-005 SHALL have port loader_ready_out, output, 1: arbiter accepts the loader element this cycle.
REQ-006 SHALL have ports loader_i_in [MBITS:0], loader_j_in [NBITS:0] and loader_element_in (float_sp), all inputs: loader write address and data.
REQ-007 SHALL have port collector_active_write_in, input, 1: collector write strobe; the collector cannot be stalled.
REQ-008 SHALL have ports collector_i_in [MBITS:0], collector_j_in [NBITS:0] and collector_element_in (float_sp), all inputs: collector write address and data.
REQ-009 SHALL have port collector_finished_in, input, 1: the collector's last-element indication.
REQ-010 SHALL have ports reg_wr_en_out (1), reg_i_out [MBITS:0], reg_j_out [NBITS:0] and reg_element_out (float_sp), all outputs: the single matrix register file write port.
REQ-011 SHALL have outputs collector_done_out (1-cycle pulse), collector_error_out (sticky), loader_timeout_out (1-cycle pulse) and busy_out (state != ARB_IDLE).

Function
REQ-012 SHALL implement FSM states ARB_IDLE, ARB_LOADER and ARB_COLLECTOR.
REQ-013 SHALL follow these transitions: IDLE->COLLECTOR on collector_active_write_in; IDLE->LOADER on loader_valid_in with no collector write; LOADER->COLLECTOR on collector_active_write_in (preemption); LOADER->IDLE when loader_valid_in is low; COLLECTOR->IDLE in the cycle after collector_active_write_in falls.
REQ-014 SHALL give the collector absolute priority: loader_ready_out = !collector_active_write_in && state != ARB_COLLECTOR, computed combinationally.
REQ-015 SHALL register the write port with 1-cycle latency: a collector strobe, or a loader valid&&ready, in cycle t drives reg_wr_en_out=1 with the matching address and data in cycle t+1.
REQ-016 SHALL never accept a loader element in the same cycle as a collector write, so no write is dropped and no port conflict occurs.
REQ-017 SHALL zero reg_wr_en_out, the address fields and the element field in any cycle with no granted write.
REQ-018 SHALL keep a collector write counter, 0..M*N, cleared on entry to ARB_COLLECTOR and incremented on each collector strobe.
REQ-019 SHALL pulse collector_done_out for one cycle on leaving ARB_COLLECTOR when the count equals M*N and collector_finished_in was seen.
REQ-020 SHALL set collector_error_out and hold it until rst when ARB_COLLECTOR exits with any other count, or when the counter would exceed M*N.
REQ-021 SHALL keep a loader wait counter that increments while loader_valid_in && !loader_ready_out and clears on acceptance or when valid drops.
REQ-022 SHALL pulse loader_timeout_out once when the wait counter reaches LOADER_MAX_WAIT, then saturate the counter without re-pulsing.
REQ-023 SHALL treat loader_valid_in falling mid-stall as a withdrawn request, with no write issued.

Reset
REQ-024 SHALL, while rst is high, set state to ARB_IDLE, clear both counters, drive every output to 0 (including collector_error_out), and drop any pending write; the next cycle's reg_wr_en_out=0.
REQ-025 SHALL, on rst asserted mid-burst, resume in ARB_IDLE; a later collector strobe starts a new burst at count 0.

Structure
REQ-026 SHALL add arbiter_state_e {ARB_IDLE, ARB_LOADER, ARB_COLLECTOR} to mpu_data_types.
REQ-027 SHALL use M, N, MBITS, NBITS and FALSE/TRUE from global_defs.
REQ-028 SHALL be a single module, with no sub-module.

Verification
REQ-029 Collector burst alone: 9 consecutive strobes with element k = k*1.0 -> 9 writes, one cycle delayed, in row-major order; collector_done_out pulses once; error stays 0.
REQ-030 Loader preemption: loader valid continuously, collector strobes at cycles 5..13 -> loader_ready_out=0 in cycles 5..13; no write lost or duplicated; loader writes resume at cycle 15.
REQ-031 Short burst: collector active for only 7 strobes -> collector_error_out=1 and stays 1 until rst; no done pulse.
REQ-032 Timeout: loader valid held through a 16-cycle collector burst -> exactly one loader_timeout_out pulse, on the 16th stalled cycle.
REQ-033 Reset mid-burst: rst at strobe 4 for 1 cycle -> all outputs 0 the next cycle; state ARB_IDLE; a following 9-strobe burst completes with done and error=0.
REQ-034 Simultaneous request: loader valid and collector strobe rise in the same IDLE cycle -> collector is granted and the loader element is written only after the burst.
